// File: rtl/rom_image_loader.sv
// Streams ioctl download bytes into SDRAM pages, replicated across banks, and keeps a per-page ROM-present map.
// Latency: per byte, one ce_ref-aligned write slot per target bank plus one clk to finish; map_hit is 1 clk after map_addr.
// Backpressure: ioctl_wait holds the HPS from byte acceptance until the last bank is written; bytes offered meanwhile are ignored.
module rom_image_loader #(
    parameter int BANKS    = 2,
    parameter int PAGE_W   = 9,
    parameter int SYS_SEGS = 4,
    parameter int BW       = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 ce_ref,
    input  logic                 ioctl_download,
    input  logic                 ioctl_wr,
    input  logic [24:0]          ioctl_addr,
    input  logic [7:0]           ioctl_dout,
    input  logic [7:0]           ioctl_index,
    input  logic [15:0]          ioctl_file_ext,
    output logic                 ioctl_wait,
    output logic                 boot_wr,
    output logic [PAGE_W+13:0]   boot_a,
    output logic [BW-1:0]        boot_bank,
    output logic [7:0]           boot_dout,
    input  logic [PAGE_W-2:0]    map_addr,
    output logic                 map_hit
);

    // Write sequencer states.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // The map covers every page that has the upper (ROM window) bit set.
    localparam int MAP_N = 1 << (PAGE_W - 1);

    // Page constants: the expansion default sits 0x11 below the top page.
    localparam logic [PAGE_W-1:0] PG_ALL1    = {PAGE_W{1'b1}};
    localparam logic [PAGE_W-1:0] PG_DEFAULT = PG_ALL1 - PAGE_W'(8'h11);

    // Fixed page placement of the four system segments within each bank.
    localparam logic [PAGE_W-1:0] PG_SYS0 = PAGE_W'(9'h000);
    localparam logic [PAGE_W-1:0] PG_SYS1 = PAGE_W'(9'h100);
    localparam logic [PAGE_W-1:0] PG_SYS2 = PAGE_W'(9'h107);
    localparam logic [PAGE_W-1:0] PG_SYS3 = PAGE_W'(9'h1FF);

    // System segments at or beyond this index have no bank to land in.
    localparam logic [10:0] SEG_LIMIT = 11'(SYS_SEGS * BANKS);
    localparam logic [10:0] SEG_DIV   = 11'(SYS_SEGS);

    // Highest bank index, and the bank used by index[7:6]==3 images (1, or 0 when there is only one bank).
    localparam logic [BW-1:0] BANK_LAST = BW'(BANKS - 1);
    localparam logic [BW-1:0] BANK_HI   = BW'((BANKS > 1) ? 1 : 0);

    // ASCII hex digit -> {valid, value}; lower-case and anything else is invalid.
    function automatic logic [4:0] hex_nib(input logic [7:0] c);
        logic [4:0] r;
        r = 5'b0;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b1, 4'(c - 8'h30)};
        end else if (c >= 8'h41 && c <= 8'h46) begin
            r = {1'b1, 4'(c - 8'h37)};
        end
        return r;
    endfunction

    logic [1:0]          state;
    logic [PAGE_W-1:0]   page;
    logic                combo;
    logic                replicate;
    logic                dl_q;
    logic [MAP_N-1:0]    rom_map;

    logic [PAGE_W-1:0]   ext_page;
    logic                ext_combo;
    logic [4:0]          ext_hi;
    logic [4:0]          ext_lo;

    logic [10:0]         seg;
    logic [10:0]         seg_div;
    logic [PAGE_W-1:0]   tgt_page;
    logic [BW-1:0]       tgt_bank;
    logic                tgt_drop;
    logic                tgt_rep;

    logic                dl_rise;
    logic                last_offset;

    assign dl_rise     = ioctl_download & ~dl_q & (ioctl_index != 8'd0);
    assign last_offset = (boot_a[13:0] == 14'h3FFF);

    // Base page decoded from the file extension's last two characters.
    always_comb begin
        ext_page  = PG_DEFAULT;
        ext_combo = 1'b0;
        ext_hi    = hex_nib(ioctl_file_ext[15:8]);
        ext_lo    = hex_nib(ioctl_file_ext[7:0]);
        if (ioctl_file_ext == 16'h5A5A) begin
            // "ZZ": image starts at page 0
            ext_page = '0;
        end else if (ioctl_file_ext == 16'h5A30) begin
            // "Z0": page 0, then jump to the top page once the first 16 KB is in
            ext_page  = '0;
            ext_combo = 1'b1;
        end else begin
            if (ext_hi[4]) begin
                ext_page[7:4] = ext_hi[3:0];
            end
            if (ext_lo[4]) begin
                ext_page[3:0] = ext_lo[3:0];
            end
        end
    end

    // Where the byte on ioctl_addr lands: page, first bank, replication and drop.
    always_comb begin
        seg           = ioctl_addr[24:14];
        seg_div       = seg / SEG_DIV;
        tgt_page      = page;
        tgt_page[7:0] = page[7:0] + ioctl_addr[21:14];
        tgt_bank      = (ioctl_index[7:6] == 2'b11) ? BANK_HI : '0;
        tgt_rep       = (ioctl_index[7:6] == 2'b01) || (ioctl_index[5:0] != 6'd0);
        tgt_drop      = 1'b0;
        if (ioctl_index == 8'd0) begin
            // System image: consecutive segments fill bank 0 first, then bank 1, ...
            tgt_rep  = 1'b0;
            tgt_bank = seg_div[BW-1:0];
            tgt_drop = (seg >= SEG_LIMIT);
            case (seg[1:0])
                2'd0:    tgt_page = PG_SYS0;
                2'd1:    tgt_page = PG_SYS1;
                2'd2:    tgt_page = PG_SYS2;
                default: tgt_page = PG_SYS3;
            endcase
        end
    end

    // Byte acceptance, ce_ref-paced write per bank, and page/combo bookkeeping.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            ioctl_wait <= 1'b0;
            boot_wr    <= 1'b0;
            boot_a     <= '0;
            boot_bank  <= '0;
            boot_dout  <= 8'd0;
            replicate  <= 1'b0;
            page       <= PG_DEFAULT;
            combo      <= 1'b0;
            dl_q       <= 1'b0;
        end else begin
            dl_q <= ioctl_download;
            case (state)
                ST_IDLE: begin
                    if (ioctl_wr && !tgt_drop) begin
                        boot_dout  <= ioctl_dout;
                        boot_a     <= {tgt_page, ioctl_addr[13:0]};
                        boot_bank  <= tgt_bank;
                        replicate  <= tgt_rep;
                        ioctl_wait <= 1'b1;
                        state      <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (ce_ref) begin
                        boot_wr <= 1'b1;
                        state   <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // Hold the request for one full ce_ref period.
                    if (ce_ref) begin
                        boot_wr <= 1'b0;
                        if (replicate && (boot_bank < BANK_LAST)) begin
                            boot_bank <= boot_bank + BW'(1);
                            state     <= ST_ARM;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                default: begin
                    ioctl_wait <= 1'b0;
                    if (combo && last_offset) begin
                        combo <= 1'b0;
                        page  <= PG_ALL1;
                    end
                    state <= ST_IDLE;
                end
            endcase
            // A new expansion download restarts page selection from its extension.
            if (dl_rise) begin
                page  <= ext_page;
                combo <= ext_combo;
            end
        end
    end

    // ROM-present map: set once a byte lands in an upper page, read back registered.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rom_map <= '0;
            map_hit <= 1'b0;
        end else begin
            if (state == ST_DONE && boot_a[PAGE_W+13]) begin
                rom_map[boot_a[PAGE_W+12:14]] <= 1'b1;
            end
            map_hit <= rom_map[map_addr];
        end
    end

endmodule

// File: tb/tb_rom_image_loader.sv
// Randomised and directed bench for rom_image_loader against a page/bank reference model.
// Captured boot_wr pulses (address, bank, data, width) are compared in order with model expectations.
// Map contents, ioctl_wait behaviour, drops and async reset are checked per scenario task.
module tb_rom_image_loader;
    localparam int BANKS    = 2;
    localparam int PAGE_W   = 9;
    localparam int SYS_SEGS = 4;

    logic               clk_sys = 1'b0;
    logic               reset = 1'b1;
    logic               ce_ref = 1'b0;
    logic               ioctl_download = 1'b0;
    logic               ioctl_wr = 1'b0;
    logic [24:0]        ioctl_addr = '0;
    logic [7:0]         ioctl_dout = '0;
    logic [7:0]         ioctl_index = '0;
    logic [15:0]        ioctl_file_ext = '0;
    logic               ioctl_wait;
    logic               boot_wr;
    logic [PAGE_W+13:0] boot_a;
    logic [0:0]         boot_bank;
    logic [7:0]         boot_dout;
    logic [PAGE_W-2:0]  map_addr = '0;
    logic               map_hit;

    int tests_run = 0;
    int tests_failed = 0;
    int ce_div = 4;

    typedef struct {
        int a;
        int bank;
        int dout;
        int width;
    } rec_t;

    rec_t cap_q[$];
    rec_t exp_q[$];

    int m_page = 'h1EE;
    bit m_combo = 1'b0;
    bit m_map[256];

    rom_image_loader #(.BANKS(BANKS), .PAGE_W(PAGE_W), .SYS_SEGS(SYS_SEGS)) dut (
        .clk_sys(clk_sys), .reset(reset), .ce_ref(ce_ref),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index), .ioctl_file_ext(ioctl_file_ext),
        .ioctl_wait(ioctl_wait), .boot_wr(boot_wr), .boot_a(boot_a), .boot_bank(boot_bank),
        .boot_dout(boot_dout), .map_addr(map_addr), .map_hit(map_hit)
    );

    always #5 clk_sys = ~clk_sys;

    // ce_ref: one-clock strobe every ce_div clocks, changed just after the rising edge
    initial begin : ce_gen
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk_sys);
            #1;
            ce_ref = (cnt == 0);
            cnt = (cnt + 1 >= ce_div) ? 0 : cnt + 1;
        end
    end

    // Pulse monitor: records each boot_wr pulse with its width in clocks
    initial begin : mon
        logic prev;
        int   w;
        rec_t r;
        prev = 1'b0;
        w = 0;
        r = '{a: 0, bank: 0, dout: 0, width: 0};
        forever begin
            @(negedge clk_sys);
            if (boot_wr && !prev) begin
                r.a = int'(boot_a);
                r.bank = int'(boot_bank);
                r.dout = int'(boot_dout);
                w = 1;
            end else if (boot_wr) begin
                w++;
            end else if (prev) begin
                r.width = w;
                cap_q.push_back(r);
            end
            prev = boot_wr;
        end
    end

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, got no end want end");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int hexval(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        return -1;
    endfunction

    function automatic void model_download(input int idx, input logic [15:0] ext);
        int h, l;
        if (idx == 0) return;
        m_combo = 1'b0;
        if (ext == 16'h5A5A) begin
            m_page = 0;
        end else if (ext == 16'h5A30) begin
            m_page = 0;
            m_combo = 1'b1;
        end else begin
            m_page = 'h1EE;
            h = hexval(ext[15:8]);
            l = hexval(ext[7:0]);
            if (h >= 0) m_page = (m_page / 256) * 256 + h * 16 + m_page % 16;
            if (l >= 0) m_page = (m_page / 16) * 16 + l;
        end
    endfunction

    // Pushes the expected writes for one byte; returns how many bank writes it causes.
    function automatic int model_byte(input int idx, input int addr, input int d);
        int seg, pg, off, b0, nb;
        rec_t r;
        off = addr % 16384;
        if (idx == 0) begin
            seg = addr / 16384;
            if (seg >= SYS_SEGS * BANKS) return 0;
            b0 = seg / SYS_SEGS;
            case (seg % 4)
                0: pg = 'h000;
                1: pg = 'h100;
                2: pg = 'h107;
                default: pg = 'h1FF;
            endcase
            nb = 1;
        end else begin
            pg = (m_page / 256) * 256 + ((m_page % 256) + (addr / 16384) % 256) % 256;
            b0 = (idx / 64 == 3) ? 1 : 0;
            if (b0 > BANKS - 1) b0 = BANKS - 1;
            nb = ((idx / 64 == 1) || (idx % 64 != 0)) ? BANKS - b0 : 1;
        end
        for (int k = 0; k < nb; k++) begin
            r.a = pg * 16384 + off;
            r.bank = b0 + k;
            r.dout = d;
            r.width = ce_div;
            exp_q.push_back(r);
        end
        if (pg >= 256) m_map[pg % 256] = 1'b1;
        if (m_combo && off == 16383) begin
            m_combo = 1'b0;
            m_page = 'h1FF;
        end
        return nb;
    endfunction

    // ---------------- stimulus ----------------
    task automatic start_download(input int idx, input logic [15:0] ext);
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        ioctl_index = 8'(idx);
        ioctl_file_ext = ext;
        ioctl_download = 1'b1;
        model_download(idx, ext);
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic send_byte(input int addr, input int d, input bit drop_dl, input bit inject,
                             output bit saw_wait, output int wait_cycles);
        @(negedge clk_sys);
        ioctl_addr = 25'(addr);
        ioctl_dout = 8'(d);
        ioctl_wr = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        saw_wait = ioctl_wait;
        if (drop_dl) ioctl_download = 1'b0;
        wait_cycles = 0;
        while (ioctl_wait && wait_cycles < 4000) begin
            if (inject && wait_cycles == 2) begin
                ioctl_wr = 1'b1;
                ioctl_addr = '0;
                ioctl_dout = 8'hEE;
            end else begin
                ioctl_wr = 1'b0;
            end
            @(negedge clk_sys);
            wait_cycles++;
        end
        ioctl_wr = 1'b0;
        tests_run++;
        if (ioctl_wait !== 1'b0) begin
            tests_failed++;
            $display("FAIL wait_release addr=%h: ioctl_wait got %b want 0 after %0d clks", addr, ioctl_wait, wait_cycles);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk_sys);
        tests_run++; if (ioctl_wait !== 1'b0) begin tests_failed++; $display("FAIL reset_wait got %b want 0", ioctl_wait); end
        tests_run++; if (boot_wr !== 1'b0) begin tests_failed++; $display("FAIL reset_wr got %b want 0", boot_wr); end
        tests_run++; if (boot_a !== '0) begin tests_failed++; $display("FAIL reset_a got %h want 0", boot_a); end
        tests_run++; if (boot_bank !== '0) begin tests_failed++; $display("FAIL reset_bank got %h want 0", boot_bank); end
        tests_run++; if (boot_dout !== 8'd0) begin tests_failed++; $display("FAIL reset_dout got %h want 0", boot_dout); end
        tests_run++; if (map_hit !== 1'b0) begin tests_failed++; $display("FAIL reset_map_hit got %b want 0", map_hit); end
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic test_system_image();
        int addrs[7];
        bit sw;
        int wc, n, d;
        ce_div = 4;
        addrs = '{2 * 16384 + 'h1234, 5 * 16384 + 'h0777, 0 * 16384 + 'h3FFF, 3 * 16384 + 'h0001,
                  7 * 16384 + 'h2000, 8 * 16384 + 'h0000, 'h1FFFFFF};
        start_download(0, 16'h0000);
        foreach (addrs[i]) begin
            d = int'($urandom_range(0, 255));
            n = model_byte(0, addrs[i], d);
            send_byte(addrs[i], d, 1'b0, 1'b0, sw, wc);
            tests_run++;
            if (sw !== (n > 0)) begin
                tests_failed++;
                $display("FAIL sys_wait addr=%h got %b want %b", addrs[i], sw, (n > 0));
            end
        end
        tests_run++;
        if (cap_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL sys_count got %0d want %0d", cap_q.size(), exp_q.size());
        end else begin
            tests_run++;
            if (cap_q[0].a !== ('h107 * 16384 + 'h1234) || cap_q[0].bank !== 0) begin
                tests_failed++;
                $display("FAIL sys_seg2 got a=%h bank=%0d want a=%h bank=0", cap_q[0].a, cap_q[0].bank, 'h107 * 16384 + 'h1234);
            end
            foreach (exp_q[i]) begin
                tests_run++;
                if (cap_q[i].a !== exp_q[i].a || cap_q[i].bank !== exp_q[i].bank ||
                    cap_q[i].dout !== exp_q[i].dout || cap_q[i].width !== exp_q[i].width) begin
                    tests_failed++;
                    $display("FAIL sys_write[%0d] got a=%h b=%0d d=%h w=%0d want a=%h b=%0d d=%h w=%0d", i,
                             cap_q[i].a, cap_q[i].bank, cap_q[i].dout, cap_q[i].width,
                             exp_q[i].a, exp_q[i].bank, exp_q[i].dout, exp_q[i].width);
                end
            end
        end
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic test_expansion_replicate();
        bit sw;
        int wc, n;
        ce_div = 3;
        start_download(1, 16'h3037);   // ".E07"
        n = model_byte(1, 'h4005, 'h5A);
        send_byte('h4005, 'h5A, 1'b0, 1'b0, sw, wc);
        tests_run++;
        if (cap_q.size() != 2 || exp_q.size() != 2) begin
            tests_failed++;
            $display("FAIL exp_count got %0d want 2 (model %0d)", cap_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                tests_run++;
                if (cap_q[i].a !== 'h420005 || cap_q[i].bank !== i || cap_q[i].dout !== 'h5A || cap_q[i].width !== 3) begin
                    tests_failed++;
                    $display("FAIL exp_write[%0d] got a=%h b=%0d d=%h w=%0d want a=420005 b=%0d d=5a w=3", i,
                             cap_q[i].a, cap_q[i].bank, cap_q[i].dout, cap_q[i].width, i);
                end
            end
        end
        @(negedge clk_sys);
        map_addr = 8'h08;
        @(negedge clk_sys);
        tests_run++;
        if (map_hit !== 1'b1) begin tests_failed++; $display("FAIL map_hit_08 got %b want 1", map_hit); end
        map_addr = 8'h09;
        @(negedge clk_sys);
        tests_run++;
        if (map_hit !== 1'(m_map[9])) begin tests_failed++; $display("FAIL map_hit_09 got %b want %b", map_hit, m_map[9]); end
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic test_combo_and_decode();
        bit sw;
        int wc, n;
        int addrs[4];
        logic [15:0] exts[4];
        int idxs[4];
        ce_div = 2;
        // combo page 0 -> last offset -> top page; then two malformed/edge decodes
        exts  = '{16'h5A30, 16'h5A30, 16'h5133, 16'h4646};
        addrs = '{'h3FFF, 'h4000, 'h0000, 'h4000};
        idxs  = '{1, 1, 1, 1};
        for (int t = 0; t < 4; t++) begin
            if (t != 1) start_download(idxs[t], exts[t]);
            n = model_byte(idxs[t], addrs[t], t + 16);
            send_byte(addrs[t], t + 16, 1'b0, 1'b0, sw, wc);
        end
        tests_run++;
        if (cap_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL combo_count got %0d want %0d", cap_q.size(), exp_q.size());
        end else begin
            tests_run++;
            if (cap_q[2].a !== 'h400000 || cap_q[4].a !== 'h1E3 * 16384 || cap_q[6].a !== 'h400000) begin
                tests_failed++;
                $display("FAIL combo_pages got %h %h %h want 400000 78c000 400000", cap_q[2].a, cap_q[4].a, cap_q[6].a);
            end
            foreach (exp_q[i]) begin
                tests_run++;
                if (cap_q[i].a !== exp_q[i].a || cap_q[i].bank !== exp_q[i].bank ||
                    cap_q[i].dout !== exp_q[i].dout || cap_q[i].width !== exp_q[i].width) begin
                    tests_failed++;
                    $display("FAIL combo_write[%0d] got a=%h b=%0d d=%h w=%0d want a=%h b=%0d d=%h w=%0d", i,
                             cap_q[i].a, cap_q[i].bank, cap_q[i].dout, cap_q[i].width,
                             exp_q[i].a, exp_q[i].bank, exp_q[i].dout, exp_q[i].width);
                end
            end
        end
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        bit sw;
        int wc, n;
        ce_div = 16;
        start_download(1, 16'h3030);   // page 0x100
        for (int t = 0; t < 4; t++) begin
            n = model_byte(1, t, 'hA0 + t);
            send_byte(t, 'hA0 + t, (t == 3), (t == 1), sw, wc);
            tests_run++;
            if (!sw || wc < 16 * n) begin
                tests_failed++;
                $display("FAIL slow_wait byte %0d got wait=%b clks=%0d want wait=1 clks>=%0d", t, sw, wc, 16 * n);
            end
        end
        tests_run++;
        if (cap_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL slow_count got %0d want %0d", cap_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                tests_run++;
                if (cap_q[i].a !== exp_q[i].a || cap_q[i].bank !== exp_q[i].bank ||
                    cap_q[i].dout !== exp_q[i].dout || cap_q[i].width !== exp_q[i].width) begin
                    tests_failed++;
                    $display("FAIL slow_write[%0d] got a=%h b=%0d d=%h w=%0d want a=%h b=%0d d=%h w=%0d", i,
                             cap_q[i].a, cap_q[i].bank, cap_q[i].dout, cap_q[i].width,
                             exp_q[i].a, exp_q[i].bank, exp_q[i].dout, exp_q[i].width);
                end
            end
        end
        cap_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        string cs;
        logic [7:0] ch, cl;
        logic [15:0] ext;
        int idx, addr, d, n, wc, sel, pa, errs;
        bit sw;
        cs = "0123456789ABCDEFZQa";
        for (int dl = 0; dl < 14; dl++) begin
            ce_div = int'($urandom_range(1, 6));
            case ($urandom_range(0, 4))
                0: idx = 0;
                1: idx = 1;
                2: idx = 'h40;
                3: idx = 'hC0;
                default: idx = int'($urandom_range(1, 255));
            endcase
            sel = int'($urandom_range(0, 5));
            ch = cs[int'($urandom_range(0, 18))];
            cl = cs[int'($urandom_range(0, 18))];
            ext = (sel == 0) ? 16'h5A5A : (sel == 1) ? 16'h5A30 : {ch, cl};
            start_download(idx, ext);
            for (int b = 0; b < 6; b++) begin
                if (idx == 0) begin
                    addr = int'($urandom_range(0, 9)) * 16384 + int'($urandom_range(0, 16383));
                end else begin
                    addr = int'($urandom_range(0, 33554431));
                    if ($urandom_range(0, 3) == 0) addr = (addr / 16384) * 16384 + 16383;
                end
                d = int'($urandom_range(0, 255));
                n = model_byte(idx, addr, d);
                send_byte(addr, d, 1'b0, 1'b0, sw, wc);
                tests_run++;
                if (sw !== (n > 0)) begin
                    tests_failed++;
                    $display("FAIL rnd_wait idx=%h addr=%h got %b want %b", idx, addr, sw, (n > 0));
                end
            end
            tests_run++;
            if (cap_q.size() != exp_q.size()) begin
                tests_failed++;
                $display("FAIL rnd_count dl=%0d got %0d want %0d", dl, cap_q.size(), exp_q.size());
            end else begin
                foreach (exp_q[i]) begin
                    tests_run++;
                    if (cap_q[i].a !== exp_q[i].a || cap_q[i].bank !== exp_q[i].bank ||
                        cap_q[i].dout !== exp_q[i].dout || cap_q[i].width !== exp_q[i].width) begin
                        tests_failed++;
                        $display("FAIL rnd_write dl=%0d [%0d] got a=%h b=%0d d=%h w=%0d want a=%h b=%0d d=%h w=%0d", dl, i,
                                 cap_q[i].a, cap_q[i].bank, cap_q[i].dout, cap_q[i].width,
                                 exp_q[i].a, exp_q[i].bank, exp_q[i].dout, exp_q[i].width);
                    end
                end
            end
            cap_q.delete();
            exp_q.delete();
            errs = 0;
            for (int p = 0; p < 8; p++) begin
                pa = int'($urandom_range(0, 255));
                map_addr = 8'(pa);
                @(negedge clk_sys);
                if (map_hit !== 1'(m_map[pa])) errs++;
            end
            tests_run++;
            if (errs != 0) begin
                tests_failed++;
                $display("FAIL rnd_map dl=%0d got %0d wrong probes want 0", dl, errs);
            end
        end
    endtask

    task automatic test_async_reset();
        int cyc, errs;
        ce_div = 8;
        start_download(1, 16'h3037);
        @(negedge clk_sys);
        ioctl_addr = 25'h0004005;
        ioctl_dout = 8'h33;
        ioctl_wr = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        cyc = 0;
        while (!boot_wr && cyc < 200) begin
            @(negedge clk_sys);
            cyc++;
        end
        tests_run++;
        if (boot_wr !== 1'b1) begin tests_failed++; $display("FAIL arst_setup boot_wr got %b want 1", boot_wr); end
        #2;
        reset = 1'b1;
        ioctl_download = 1'b0;
        #1;
        tests_run++; if (boot_wr !== 1'b0) begin tests_failed++; $display("FAIL arst_wr got %b want 0", boot_wr); end
        tests_run++; if (ioctl_wait !== 1'b0) begin tests_failed++; $display("FAIL arst_wait got %b want 0", ioctl_wait); end
        m_page = 'h1EE;
        m_combo = 1'b0;
        foreach (m_map[i]) m_map[i] = 1'b0;
        @(negedge clk_sys);
        reset = 1'b0;
        errs = 0;
        for (int i = 0; i < 256; i++) begin
            map_addr = 8'(i);
            @(negedge clk_sys);
            if (map_hit !== 1'b0) errs++;
        end
        tests_run++;
        if (errs != 0) begin tests_failed++; $display("FAIL arst_map got %0d set entries want 0", errs); end
        cap_q.delete();
        exp_q.delete();
    endtask

    initial begin
        foreach (m_map[i]) m_map[i] = 1'b0;
        test_reset();
        test_system_image();
        test_expansion_replicate();
        test_combo_and_decode();
        test_back_to_back();
        test_random();
        test_async_reset();
        test_expansion_replicate();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
